// File: rtl/dot_accum_requant.sv
// Saturating dot-product accumulator with bias, followed by a rounding right-shift
// requantizer and INT8/INT4/BIN clamp, presenting one result per vector on valid/ready.
module dot_accum_requant #(
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         prec,
  input  logic [31:0]        bias,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_prod,
  input  logic               in_first,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic               out_sat
);

  typedef enum logic [1:0] {IDLE, ACC, REQ, OUT} state_t;
  state_t state, state_nxt;

  localparam logic signed [ACC_W:0] I8_HI = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] I8_LO = (ACC_W+1)'(-128);
  localparam logic signed [ACC_W:0] I4_HI = (ACC_W+1)'(7);
  localparam logic signed [ACC_W:0] I4_LO = (ACC_W+1)'(-8);

  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic [1:0]         prec_q;
  logic [SHIFT_W-1:0] shift_q;

  logic beat, acc_load;

  assign in_ready = (state == IDLE) || (state == ACC);
  assign beat     = in_valid && in_ready;
  assign acc_load = beat && (in_first || (state == ACC));

  // One extra bit of headroom: both addends fit in ACC_W bits, so overflow shows
  // up as a disagreement between the top two bits of the sum.
  logic [ACC_W:0]   sum_base, sum_wide;
  logic [ACC_W-1:0] sum_sat;
  logic             sum_ovf;

  always_comb begin
    sum_base = in_first ? {{(ACC_W-31){bias[31]}}, bias} : {acc[ACC_W-1], acc};
    sum_wide = sum_base + {{(ACC_W-31){in_prod[31]}}, in_prod};
    sum_ovf  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    sum_sat  = sum_wide[ACC_W-1:0];
    if (sum_ovf) begin
      sum_sat = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  logic [ACC_W:0]        rnd, acc_x;
  logic signed [ACC_W:0] r;
  logic [31:0]           res;
  logic                  clamp;

  always_comb begin
    acc_x = {acc[ACC_W-1], acc};
    rnd   = (ACC_W+1)'(1) << shift_q;
    rnd   = rnd >> 1;
    r     = signed'(acc_x + rnd) >>> shift_q;
    clamp = 1'b0;
    res   = r[31:0];
    case (prec_q)
      2'd0: begin
        if (r > I8_HI) begin
          res   = 32'd127;
          clamp = 1'b1;
        end else if (r < I8_LO) begin
          res   = 32'hFFFF_FF80;
          clamp = 1'b1;
        end
      end
      2'd1: begin
        if (r > I4_HI) begin
          res   = 32'd7;
          clamp = 1'b1;
        end else if (r < I4_LO) begin
          res   = 32'hFFFF_FFF8;
          clamp = 1'b1;
        end
      end
      default: res = r[ACC_W] ? '1 : 32'd1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (beat && in_first) state_nxt = in_last ? REQ : ACC;
      ACC:     if (beat && in_last) state_nxt = REQ;
      REQ:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      prec_q    <= '0;
      shift_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (acc_load) begin
        acc <= sum_sat;
        ovf <= (in_first ? 1'b0 : ovf) | sum_ovf;
        if (in_first) begin
          prec_q  <= prec;
          shift_q <= shift;
        end
      end
      if (state == REQ) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_sat   <= ovf | clamp;
      end else if ((state == OUT) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dot_accum_requant.sv
// Bench for dot_accum_requant: 40-bit and 32-bit accumulator instances share stimulus and
// are checked every cycle against a transaction-level model, plus literal directed cases.
module tb_dot_accum_requant;

  bit clk;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [1:0]  prec = '0;
  logic [31:0] bias = '0;
  logic [4:0]  shift = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_prod = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready40, out_valid40, out_sat40;
  logic [31:0] out_data40;
  logic        in_ready32, out_valid32, out_sat32;
  logic [31:0] out_data32;

  dot_accum_requant #(.ACC_W(40), .SHIFT_W(5)) dut40 (
    .clk(clk), .rst(rst), .prec(prec), .bias(bias), .shift(shift),
    .in_valid(in_valid), .in_ready(in_ready40), .in_prod(in_prod),
    .in_first(in_first), .in_last(in_last), .out_valid(out_valid40),
    .out_ready(out_ready), .out_data(out_data40), .out_sat(out_sat40)
  );

  dot_accum_requant #(.ACC_W(32), .SHIFT_W(5)) dut32 (
    .clk(clk), .rst(rst), .prec(prec), .bias(bias), .shift(shift),
    .in_valid(in_valid), .in_ready(in_ready32), .in_prod(in_prod),
    .in_first(in_first), .in_last(in_last), .out_valid(out_valid32),
    .out_ready(out_ready), .out_data(out_data32), .out_sat(out_sat32)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Result of one vector from plain arithmetic on the list of accepted products.
  function automatic void compute(input longint q[$], input longint b, input int p,
                                  input int s, input int w, output int d, output bit sat);
    longint hi, lo, a, r;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -hi - 1;
    sat = 1'b0;
    a   = b;
    foreach (q[i]) begin
      a = a + q[i];
      if (a > hi) begin a = hi; sat = 1'b1; end
      else if (a < lo) begin a = lo; sat = 1'b1; end
    end
    r = (a + ((s > 0) ? (longint'(1) <<< (s - 1)) : longint'(0))) >>> s;
    if (p == 0) begin
      if (r > 127) begin d = 127; sat = 1'b1; end
      else if (r < -128) begin d = -128; sat = 1'b1; end
      else d = int'(r);
    end else if (p == 1) begin
      if (r > 7) begin d = 7; sat = 1'b1; end
      else if (r < -8) begin d = -8; sat = 1'b1; end
      else d = int'(r);
    end else begin
      d = (r >= 0) ? 1 : -1;
    end
  endfunction

  bit     m_active = 1'b0, m_pend = 1'b0, m_valid = 1'b0;
  longint m_q[$];
  longint m_bias = 0;
  int     m_prec = 0, m_shift = 0;
  int     m_d40 = 0, m_d32 = 0;
  bit     m_s40 = 1'b0, m_s32 = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_pend   = 1'b0;
      m_valid  = 1'b0;
      m_q.delete();
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (m_pend) begin
      m_pend  = 1'b0;
      m_valid = 1'b1;
    end else if (in_valid) begin
      if (in_first) begin
        m_q.delete();
        m_bias   = longint'($signed(bias));
        m_prec   = int'(prec);
        m_shift  = int'(shift);
        m_active = 1'b1;
      end
      if (m_active) m_q.push_back(longint'($signed(in_prod)));
      if (m_active && in_last) begin
        compute(m_q, m_bias, m_prec, m_shift, 40, m_d40, m_s40);
        compute(m_q, m_bias, m_prec, m_shift, 32, m_d32, m_s32);
        m_active = 1'b0;
        m_pend   = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready40", 32'(in_ready40), 32'(!m_pend && !m_valid));
      chk("in_ready32", 32'(in_ready32), 32'(!m_pend && !m_valid));
      chk("out_valid40", 32'(out_valid40), 32'(m_valid));
      chk("out_valid32", 32'(out_valid32), 32'(m_valid));
      if (m_valid) begin
        chk("model data40", out_data40, 32'(m_d40));
        chk("model sat40", 32'(out_sat40), 32'(m_s40));
        chk("model data32", out_data32, 32'(m_d32));
        chk("model sat32", 32'(out_sat32), 32'(m_s32));
      end
    end
  end

  task automatic send_beat(input int p, input bit f, input bit l);
    int   guard;
    logic rdy;
    guard    = 0;
    in_valid = 1'b1;
    in_prod  = 32'(p);
    in_first = f;
    in_last  = l;
    do begin
      @(negedge clk);
      rdy = in_ready40;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 50);
    chk("beat accepted", 32'(rdy), 32'd1);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, " out_valid"}, 32'(out_valid40), 32'd0);
    chk({name, " out_data"}, out_data40, 32'd0);
    chk({name, " out_sat"}, 32'(out_sat40), 32'd0);
    chk({name, " in_ready"}, 32'(in_ready40), 32'd1);
    chk({name, " out_data32"}, out_data32, 32'd0);
  endtask

  // Called at posedge+1; fmask marks which beats carry in_first, the final beat carries in_last.
  task automatic run_vec(input string name, input logic [1:0] p, input int b, input int s,
                         input int prods[4], input int n, input int fmask, input int stall,
                         input int exp_d, input bit exp_s);
    int lat, lf;
    out_ready = 1'b0;
    prec  = p;
    bias  = 32'(b);
    shift = 5'(s);
    lf = 0;
    for (int i = 0; i < n; i++) if (fmask[i]) lf = i;
    for (int i = 0; i < n; i++) begin
      send_beat(prods[i], fmask[i], i == n - 1);
      if (i >= lf) begin
        prec  = 2'($urandom);
        bias  = $urandom;
        shift = 5'($urandom);
      end
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid40 && lat < 20);
    chk({name, " latency"}, 32'(lat), 32'd2);
    chk({name, " data40"}, out_data40, 32'(exp_d));
    chk({name, " sat40"}, 32'(out_sat40), 32'(exp_s));
    chk({name, " data32"}, out_data32, 32'(exp_d));
    chk({name, " sat32"}, 32'(out_sat32), 32'(exp_s));
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_first = 1'b1;
      in_last  = 1'b1;
      in_prod  = $urandom;
      @(negedge clk);
      chk({name, " stall valid"}, 32'(out_valid40), 32'd1);
      chk({name, " stall data"}, out_data40, 32'(exp_d));
      chk({name, " stall sat"}, 32'(out_sat40), 32'(exp_s));
      chk({name, " stall in_ready"}, 32'(in_ready40), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({name, " post valid"}, 32'(out_valid40), 32'd0);
    chk({name, " post in_ready"}, 32'(in_ready40), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;

    run_vec("int8",       2'd0, 0,  0, '{3, 4, -2, 0},                        3, 'b1,    0, 5,   1'b0);
    run_vec("rnd_pos",    2'd0, 10, 2, '{5, 0, 0, 0},                         1, 'b1,    0, 4,   1'b0);
    run_vec("rnd_neg",    2'd0, 0,  1, '{-7, 0, 0, 0},                        1, 'b1,    0, -3,  1'b0);
    run_vec("int4_clamp", 2'd1, 0,  0, '{16129, 16129, 0, 0},                 2, 'b1,    0, 7,   1'b1);
    run_vec("bin_neg",    2'd2, 0,  0, '{1, -1, -1, 0},                       3, 'b1,    0, -1,  1'b0);
    run_vec("bin_pos",    2'd3, 0,  0, '{1, -1, 0, 0},                        2, 'b1,    0, 1,   1'b0);
    run_vec("acc_sat",    2'd0, 0,  0, '{32'h7FFFFFFF, 32'h7FFFFFFF, -1, 0},  3, 'b1,    0, 127, 1'b1);
    run_vec("backpress",  2'd0, 0,  0, '{20, 22, 0, 0},                       2, 'b1,    5, 42,  1'b0);
    run_vec("restart",    2'd0, 0,  0, '{9, 9, 2, 3},                         4, 'b0101, 0, 5,   1'b0);
    run_vec("stray",      2'd0, 0,  0, '{77, 2, 3, 0},                        3, 'b010,  0, 5,   1'b0);

    // Reset in the middle of accumulation drops the vector.
    prec = 2'd0;
    bias = '0;
    shift = '0;
    send_beat(5, 1'b1, 1'b0);
    send_beat(6, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("mid_rst");
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst no output", 32'(out_valid40), 32'd0);
    end
    @(posedge clk);
    #1;

    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_first = ($urandom_range(0, 3) == 0);
      in_last  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0, 1:    in_prod = 32'($urandom_range(0, 2000)) - 32'd1000;
        2:       in_prod = $urandom;
        default: in_prod = 32'($urandom_range(0, 2097152)) - 32'd1048576;
      endcase
      prec      = 2'($urandom);
      bias      = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000;
      shift     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
